// File: rtl/core_pkg.sv
// Shared types and AXI constants for the dcache AXI line-transfer controller.
// Holds the FSM state enum, burst/size/resp encodings and the line geometry.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RD_DONE,
        S_AW,
        S_W,
        S_B,
        S_WR_DONE
    } state_t;

    localparam int LINE_BEATS = 8;
    localparam int BEAT_W     = 3;
    localparam int DATA_W     = 64;
    localparam int AXI_ID_W   = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [7:0] LEN_LINE   = 8'(LINE_BEATS - 1);
    localparam logic [7:0] STRB_ALL   = 8'hFF;

endpackage

// File: rtl/line_buf.sv
// 8 x 64-bit line buffer: one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module line_buf
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [BEAT_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BEAT_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [LINE_BEATS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dcache_axi_ctl.sv
// Moves one 64-byte dcache line over AXI4 as an 8-beat INCR burst.
// Ports: clk/rst (async active-low), dcache req/fifo side, AXI4 AR/R/AW/W/B master.
module dcache_axi_ctl
    import core_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int ID     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                axi_req,
    input  logic                axi_rw,
    input  logic [ADDR_W-1:0]   axi_req_addr,
    input  logic                axi_fifo_wen,
    input  logic [DATA_W-1:0]   axi_fifo_data_i,
    input  logic [8:0]          axi_fifo_idx,
    input  logic                axi_fifo_done,
    output logic                axi_ready,
    output logic                axi_done,
    output logic [DATA_W-1:0]   axi_data_o,
    output logic                axi_err,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [AXI_ID_W-1:0] arid,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [AXI_ID_W-1:0] awid,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [7:0]          wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp
);

    state_t            state, next;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] rcnt, wcnt, wptr;
    logic              err;
    logic              r_fire, w_fire, b_fire, push, last_w;
    logic              buf_we;
    logic [BEAT_W-1:0] buf_waddr, buf_raddr;
    logic [DATA_W-1:0] buf_wdata, buf_rdata;
    logic              unused_bits;

    assign unused_bits = ^{axi_fifo_idx[5:0], axi_req_addr[5:0]};

    assign r_fire = (state == S_R) && rvalid;
    assign w_fire = (state == S_W) && wready;
    assign b_fire = (state == S_B) && bvalid;
    assign push   = axi_fifo_wen && (state == S_IDLE || state == S_AW);
    assign last_w = (wcnt == BEAT_W'(LINE_BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:    if (axi_req) next = axi_rw ? S_AW : S_AR;
            S_AR:      if (arready) next = S_R;
            S_R:       if (rvalid && rlast) next = S_RD_DONE;
            S_RD_DONE: if (axi_fifo_done) next = S_IDLE;
            S_AW:      if (awready) next = S_W;
            S_W:       if (wready && last_w) next = S_B;
            S_B:       if (bvalid) next = S_WR_DONE;
            S_WR_DONE: next = S_IDLE;
            default:   next = S_IDLE;
        endcase
    end

    always_comb begin
        axi_ready = (state == S_IDLE);
        axi_done  = (state == S_RD_DONE) || (state == S_WR_DONE);
        arvalid   = (state == S_AR);
        rready    = (state == S_R);
        awvalid   = (state == S_AW);
        wvalid    = (state == S_W);
        wlast     = (state == S_W) && last_w;
        bready    = (state == S_B);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
            rcnt <= '0;
            wcnt <= '0;
            wptr <= '0;
            err  <= 1'b0;
        end else begin
            if (state == S_IDLE && axi_req) begin
                addr <= {axi_req_addr[ADDR_W-1:6], 6'b0};
            end
            if (r_fire) begin
                rcnt <= rlast ? '0 : rcnt + 1'b1;
            end
            if (w_fire) begin
                wcnt <= wcnt + 1'b1;
            end
            // A finished line frees the fifo; new pushes start at beat 0.
            if ((state == S_RD_DONE || state == S_WR_DONE) && next == S_IDLE) begin
                wptr <= '0;
            end else if (push) begin
                wptr <= wptr + 1'b1;
            end
            if ((r_fire && rresp != RESP_OKAY) || (b_fire && bresp != RESP_OKAY)) begin
                err <= 1'b1;
            end
        end
    end

    // Read beats and fifo pushes never coincide, so one write port suffices.
    assign buf_we    = r_fire || push;
    assign buf_waddr = r_fire ? rcnt : wptr;
    assign buf_wdata = r_fire ? rdata : axi_fifo_data_i;
    assign buf_raddr = (state == S_RD_DONE) ? axi_fifo_idx[8:6] : wcnt;

    line_buf u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    assign axi_data_o = buf_rdata;
    assign wdata      = buf_rdata;
    assign axi_err    = err;

    assign araddr  = addr;
    assign awaddr  = addr;
    assign arid    = AXI_ID_W'(ID);
    assign awid    = AXI_ID_W'(ID);
    assign arlen   = LEN_LINE;
    assign awlen   = LEN_LINE;
    assign arsize  = SIZE_8B;
    assign awsize  = SIZE_8B;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign wstrb   = STRB_ALL;

endmodule

// File: tb/tb_dcache_axi_ctl.sv
// Scoreboard bench for dcache_axi_ctl: directed reads/writes with an AXI slave model.
// Stimulus pushes expectations; one negedge monitor pops and compares them.
module tb_dcache_axi_ctl;

    logic        clk = 0;
    logic        rst = 0;
    logic        axi_req = 0, axi_rw = 0;
    logic [63:0] axi_req_addr = '0;
    logic        axi_fifo_wen = 0;
    logic [63:0] axi_fifo_data_i = '0;
    logic [8:0]  axi_fifo_idx = '0;
    logic        axi_fifo_done = 0;
    logic        axi_ready, axi_done, axi_err;
    logic [63:0] axi_data_o;
    logic        arvalid, arready = 0;
    logic [63:0] araddr;
    logic [3:0]  arid, awid;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        rvalid = 0, rready, rlast = 0;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        awvalid, awready = 0;
    logic [63:0] awaddr, wdata;
    logic        wvalid, wready = 0, wlast;
    logic        bvalid = 0, bready;
    logic [1:0]  bresp = '0;

    always #5 clk = ~clk;

    dcache_axi_ctl #(.ADDR_W(64), .ID(0)) dut (
        .clk(clk), .rst(rst),
        .axi_req(axi_req), .axi_rw(axi_rw), .axi_req_addr(axi_req_addr),
        .axi_fifo_wen(axi_fifo_wen), .axi_fifo_data_i(axi_fifo_data_i),
        .axi_fifo_idx(axi_fifo_idx), .axi_fifo_done(axi_fifo_done),
        .axi_ready(axi_ready), .axi_done(axi_done),
        .axi_data_o(axi_data_o), .axi_err(axi_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    logic [63:0] exp_ar[$], exp_aw[$], exp_rd[$];
    logic [64:0] exp_w[$];
    logic [4:0]  exp_st[$];
    logic        probe = 0;
    logic        end_req = 0, end_ack = 0;
    int          n_chk = 0, n_fail = 0;

    // status word: {axi_ready, axi_done, axi_err, rready, any valid/bready}
    function automatic logic [4:0] st(logic rdy, logic dn, logic er, logic rr);
        return {rdy, dn, er, rr, 1'b0};
    endfunction

    task automatic chk(string nm, logic [64:0] act, logic [64:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_st.size() > 0) begin
            chk("status", 65'({axi_ready, axi_done, axi_err, rready,
                              arvalid | awvalid | wvalid | bready}),
                65'(exp_st.pop_front()));
        end
        if (arvalid) begin
            if (exp_ar.size() == 0) begin
                chk("ar_extra", 65'(1), 65'(0));
            end else begin
                chk("araddr", 65'(araddr), 65'(exp_ar[0]));
                if (arready) begin
                    chk("ar_fmt", 65'({arlen, arsize, arburst, arid}),
                        65'({8'd7, 3'd3, 2'd1, 4'd0}));
                    void'(exp_ar.pop_front());
                end
            end
        end
        if (awvalid) begin
            if (exp_aw.size() == 0) begin
                chk("aw_extra", 65'(1), 65'(0));
            end else begin
                chk("awaddr", 65'(awaddr), 65'(exp_aw[0]));
                if (awready) begin
                    chk("aw_fmt", 65'({awlen, awsize, awburst, awid}),
                        65'({8'd7, 3'd3, 2'd1, 4'd0}));
                    void'(exp_aw.pop_front());
                end
            end
        end
        if (wvalid && wready) begin
            if (exp_w.size() == 0) begin
                chk("w_extra", 65'(1), 65'(0));
            end else begin
                chk("w_beat", {wlast, wdata}, exp_w.pop_front());
                chk("wstrb", 65'(wstrb), 65'(8'hFF));
            end
        end
        if (probe) begin
            if (exp_rd.size() == 0) begin
                chk("rd_extra", 65'(1), 65'(0));
            end else begin
                chk("rd_data", {axi_done, axi_data_o}, {1'b1, exp_rd.pop_front()});
            end
        end
        if (end_req && !end_ack) begin
            chk("queues_empty",
                65'(exp_ar.size() + exp_aw.size() + exp_w.size() +
                    exp_rd.size() + exp_st.size()), 65'(0));
            end_ack = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(string nm);
        $display("FAIL timeout waiting for %s", nm);
        $fatal(1);
    endtask

    task automatic issue(logic rw, logic [63:0] a);
        axi_req = 1; axi_rw = rw; axi_req_addr = a;
        tick();
        axi_req = 0;
    endtask

    task automatic push_line(logic [63:0] base);
        for (int b = 0; b < 8; b++) begin
            axi_fifo_wen = 1;
            axi_fifo_data_i = base + 64'(b);
            tick();
        end
        axi_fifo_wen = 0;
    endtask

    task automatic ar_slave(int dly);
        int t = 0;
        while (!arvalid) begin
            tick();
            if (++t > 50) timeout("arvalid");
        end
        repeat (dly) tick();
        arready = 1;
        tick();
        arready = 0;
    endtask

    task automatic aw_slave(int dly);
        int t = 0;
        while (!awvalid) begin
            tick();
            if (++t > 50) timeout("awvalid");
        end
        repeat (dly) tick();
        awready = 1;
        tick();
        awready = 0;
    endtask

    // Returns early presenting beat stop_b unaccepted (for the reset case).
    task automatic r_slave(int err_b, int stop_b);
        for (int b = 0; b < 8; b++) begin
            int t = 0;
            rvalid = 1;
            rdata  = 64'((b + 1) * 'h11);
            rresp  = (b == err_b) ? 2'd2 : 2'd0;
            rlast  = (b == 7);
            if (b == stop_b) return;
            while (!rready) begin
                tick();
                if (++t > 50) timeout("rready");
            end
            tick();
        end
        rvalid = 0; rlast = 0; rresp = 0;
    endtask

    task automatic rd_finish(logic e);
        exp_st.push_back(st(0, 1, e, 0));
        probe = 1;
        axi_fifo_idx = 9'd64;  exp_rd.push_back(64'h22); tick();
        axi_fifo_idx = 9'd200; exp_rd.push_back(64'h44); tick();
        axi_fifo_idx = 9'd448; exp_rd.push_back(64'h88); tick();
        probe = 0;
        axi_fifo_done = 1;
        tick();
        axi_fifo_done = 0;
        exp_st.push_back(st(1, 0, e, 0));
    endtask

    task automatic w_slave(logic toggle);
        for (int c = 0; c < 64; c++) begin
            wready = toggle ? (c % 2 == 0) : 1'b1;
            if (wvalid && wready && wlast) begin
                tick();
                wready = 0;
                return;
            end
            tick();
        end
        timeout("wlast");
    endtask

    task automatic b_slave(logic [1:0] resp);
        int t = 0;
        while (!bready) begin
            tick();
            if (++t > 50) timeout("bready");
        end
        bvalid = 1; bresp = resp;
        tick();
        bvalid = 0; bresp = 0;
    endtask

    task automatic exp_line_w(logic [63:0] base);
        for (int b = 0; b < 8; b++) exp_w.push_back({b == 7, base + 64'(b)});
    endtask

    initial begin
        repeat (2) tick();
        exp_st.push_back(st(1, 0, 0, 0));
        tick();
        rst = 1;
        tick();
        exp_st.push_back(st(1, 0, 0, 0));
        tick();

        // plain line read
        exp_ar.push_back(64'h8000_0040);
        issue(0, 64'h8000_0047);
        ar_slave(0);
        r_slave(-1, -1);
        rd_finish(0);
        tick();

        // plain line write, done for exactly one cycle
        push_line(64'hA0);
        exp_aw.push_back(64'h8000_1000);
        exp_line_w(64'hA0);
        issue(1, 64'h8000_1000);
        aw_slave(0);
        w_slave(0);
        b_slave(0);
        exp_st.push_back(st(0, 1, 0, 0));
        tick();
        exp_st.push_back(st(1, 0, 0, 0));
        tick();

        // backpressure: toggling WREADY, delayed ARREADY
        push_line(64'hB0);
        exp_aw.push_back(64'h8000_2000);
        exp_line_w(64'hB0);
        issue(1, 64'h8000_2000);
        aw_slave(2);
        w_slave(1);
        b_slave(0);
        tick();
        tick();
        exp_ar.push_back(64'h8000_2080);
        issue(0, 64'h8000_2088);
        ar_slave(5);
        r_slave(-1, -1);
        rd_finish(0);
        tick();

        // write then read with req held across done
        push_line(64'hC0);
        exp_aw.push_back(64'h8000_3000);
        exp_line_w(64'hC0);
        axi_req = 1; axi_rw = 1; axi_req_addr = 64'h8000_3000;
        tick();
        aw_slave(0);
        w_slave(0);
        b_slave(0);
        exp_st.push_back(st(0, 1, 0, 0));
        tick();
        axi_rw = 0;
        axi_req_addr = 64'h8000_3040;
        exp_ar.push_back(64'h8000_3040);
        exp_st.push_back(st(1, 0, 0, 0));
        tick();
        axi_req = 0;
        ar_slave(0);
        r_slave(-1, -1);
        rd_finish(0);
        tick();

        // error response is sticky, burst still completes
        exp_ar.push_back(64'h8000_4000);
        issue(0, 64'h8000_4000);
        ar_slave(0);
        r_slave(3, -1);
        rd_finish(1);
        tick();
        exp_ar.push_back(64'h8000_4400);
        issue(0, 64'h8000_4400);
        ar_slave(0);
        r_slave(-1, -1);
        rd_finish(1);
        tick();

        // reset during beat 4, then a clean read
        exp_ar.push_back(64'h8000_5000);
        issue(0, 64'h8000_5000);
        ar_slave(0);
        r_slave(-1, 4);
        rst = 0;
        #1;
        exp_st.push_back(st(1, 0, 0, 0));
        @(negedge clk);
        rvalid = 0; rlast = 0;
        tick();
        rst = 1;
        tick();
        exp_ar.push_back(64'h8000_6000);
        issue(0, 64'h8000_6010);
        ar_slave(0);
        r_slave(-1, -1);
        rd_finish(0);

        repeat (3) tick();
        end_req = 1;
        for (int t = 0; t < 10 && !end_ack; t++) tick();
        if (!end_ack) timeout("monitor");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/dcache_axi_ctl.md
DCACHE_AXI_CTL -- requirements
Module: dcache_axi_ctl

Interface
REQ-001 SHALL have parameters: ADDR_W = 64 (AXI address width); ID = 0 (constant AXI ID driven on ARID/AWID).
REQ-002 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock, reset asynchronous and active-low.
REQ-003 SHALL have dcache-side inputs: axi_req (1, request level); axi_rw (1, 0=read, 1=write); axi_req_addr (64, line address); axi_fifo_wen (1, push write beat); axi_fifo_data_i (64, write beat); axi_fifo_idx (9, read beat selector in bits, beat = idx[8:6]); axi_fifo_done (1, dcache finished consuming read line).
REQ-004 SHALL have dcache-side outputs: axi_ready (1, idle and accepting); axi_done (1, transfer complete); axi_data_o (64, selected read beat); axi_err (1, sticky bus error).
REQ-005 SHALL have an AXI4 master interface: AR/AW valid, ready, addr, id, len, size, burst; R valid, ready, data, resp, last; W valid, ready, data, strb, last; B valid, ready, resp.

Function
REQ-006 SHALL implement an FSM with states IDLE, AR, R, RD_DONE, AW, W, B, WR_DONE.
REQ-007 SHALL drive axi_ready=1 only in IDLE.
REQ-008 SHALL leave IDLE when axi_req=1: go to AR if axi_rw=0, or AW if axi_rw=1. The address SHALL be latched with bits [5:0] forced to 0.
REQ-009 SHALL issue every burst as INCR, len=7, size=3 (8 beats x 8 bytes = one 64-byte line), WSTRB=8'hFF.
REQ-010 SHALL, in AR/AW, hold valid with stable address until ready. The state SHALL advance on the cycle valid&ready is seen.
REQ-011 SHALL, in R, drive RREADY=1 and store each accepted beat into an 8x64 line buffer at index 0..7. It SHALL go to RD_DONE on the beat with RLAST.
REQ-012 SHALL, in RD_DONE, hold axi_done=1 with axi_data_o = buffer[axi_fifo_idx[8:6]] combinationally. It SHALL return to IDLE on the cycle after axi_fifo_done=1.
REQ-013 SHALL store each axi_fifo_wen push at the write pointer, which increments modulo 8. The pointer SHALL clear on entering IDLE from WR_DONE/RD_DONE.
REQ-014 SHALL, in W, send buffer[0..7] in order, advancing only on WVALID&WREADY, with WLAST on beat 7. It SHALL then go to B.
REQ-015 SHALL, in B, drive BREADY=1 and go to WR_DONE on BVALID.
REQ-016 SHALL, in WR_DONE, assert axi_done for exactly one cycle and then go to IDLE. A pending axi_req with axi_rw=0 SHALL then start a read.
REQ-017 SHALL set axi_err (sticky until reset) on any RRESP or BRESP != 0. The burst SHALL still complete normally.
REQ-018 SHALL ignore axi_fifo_wen outside IDLE/AW.
REQ-019 SHALL drive axi_done=0 in all other states.
REQ-020 SHALL ignore changes on axi_req and axi_req_addr while not in IDLE.
REQ-021 SHALL allow one outstanding transaction only, with no read/write overlap.

Reset
REQ-022 On rst=0 the block SHALL enter IDLE with: all valid/ready outputs 0; axi_done=0; axi_err=0; axi_ready=1; pointers and beat counters 0.
REQ-023 Reset mid-burst SHALL abandon the transaction immediately without completing the handshake. The line buffer contents SHALL be don't-care.

Structure
REQ-024 SHALL place FSM state enum, AXI burst/size/resp constants, and LINE_BEATS=8 in shared package core_pkg.
REQ-025 SHALL use one sub-module, line_buf (8x64 register file, 1 write port, 1 async read port).

Verification
REQ-026 Read: axi_req=1, rw=0, addr=0x8000_0047 -> ARADDR=0x8000_0040, ARLEN=7. Slave returns beats 0x11..0x88 -> after RLAST, axi_done=1; idx=64 reads 0x22, idx=448 reads 0x88. axi_fifo_done -> IDLE next cycle.
REQ-027 Write: push 0xA0..0xA7, then axi_req=1, rw=1, addr=0x8000_1000 -> AWADDR=0x8000_1000. W beats 0xA0..0xA7 with WLAST on beat 7. BVALID -> axi_done high one cycle.
REQ-028 Backpressure: WREADY toggles 1010..., ARREADY delayed 5 cycles -> no beat dropped or duplicated, ARADDR stable while waiting.
REQ-029 Write then read back-to-back: axi_req held, rw flips to 0 in the cycle after axi_done -> AR issued, no second AW.
REQ-030 Error: RRESP=2 on beat 3 -> axi_err=1, burst completes, axi_err stays 1 after next OKAY burst.
REQ-031 Reset asserted during beat 4 of R -> RREADY=0, axi_ready=1, axi_done=0; a new read then completes normally.
